// File: rtl/cla_multibyte_add_seq_pkg.sv
// Shared definitions for the multi-byte CLA add/subtract sequencer:
// FSM state encoding, operation encoding, index-width helper and the
// 4-bit lookahead carry equations used by CLA_Adder8.
package cla_multibyte_add_seq_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Byte index width: clog2(nbytes), never below one bit.
  function automatic int unsigned idx_width(input int unsigned nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

  // Flattened lookahead carries for a 4-bit group; bit 0 is the carry in,
  // bit 4 the group carry out.
  function automatic logic [4:0] cla4_carry(input logic [3:0] g,
                                            input logic [3:0] p,
                                            input logic       cin);
    logic [4:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | ((&p) & cin);
    return c;
  endfunction

endpackage

// File: rtl/cla_multibyte_add_seq_cla8.sv
// CLA_Adder8: combinational 8-bit carry-lookahead adder built from two
// 4-bit lookahead groups.
//   i_a, i_b  : 8-bit operands
//   i_cin     : carry in
//   o_sum_c   : 8-bit sum
//   o_cout_c  : carry out of bit 7
module CLA_Adder8
  import cla_multibyte_add_seq_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum_c,
  output logic       o_cout_c
);

  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [4:0] w_c_lo;
  logic [4:0] w_c_hi;

  // Generate/propagate, then group carries with the upper group chained on
  // the lower group's carry out.
  always_comb begin
    w_g      = i_a & i_b;
    w_p      = i_a ^ i_b;
    w_c_lo   = cla4_carry(w_g[3:0], w_p[3:0], i_cin);
    w_c_hi   = cla4_carry(w_g[7:4], w_p[7:4], w_c_lo[4]);
    o_sum_c  = w_p ^ {w_c_hi[3:0], w_c_lo[3:0]};
    o_cout_c = w_c_hi[4];
  end

endmodule

// File: rtl/cla_multibyte_add_seq.sv
// Multi-byte add/subtract sequencer. Runs NBYTES*8-bit operands through a
// single 8-bit CLA one byte per clock, LSB first, chaining the carry through
// a register. Subtraction is A + ~B + 1.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request (sampled in IDLE only) with sub, a, b
//   busy      : high in RUN and DONE
//   done      : one-cycle pulse; result/cout/ovf valid from here until next start
//   result    : sum/difference modulo 2^W
//   cout      : final carry (sub: 1 = no borrow)
//   ovf       : two's-complement signed overflow
module cla_multibyte_add_seq
  import cla_multibyte_add_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sub,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] result,
  output logic                     cout,
  output logic                     ovf
);

  localparam int unsigned W     = BYTE_W * NBYTES;
  localparam int unsigned IDX_W = idx_width(NBYTES);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_busy;
  logic               r_done;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_result;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;
  logic [IDX_W-1:0]   r_idx;
  logic [BYTE_W-1:0]  w_a_byte;
  logic [BYTE_W-1:0]  w_b_byte;
  logic [BYTE_W-1:0]  w_sum;
  logic               w_cout;
  logic               w_last;

  // Select the current byte of each operand.
  always_comb begin
    w_a_byte = '0;
    w_b_byte = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_byte = r_a[BYTE_W*i +: BYTE_W];
        w_b_byte = r_b[BYTE_W*i +: BYTE_W];
      end
    end
    w_last = (r_idx == IDX_W'(NBYTES - 1));
  end

  CLA_Adder8 u_cla (
    .i_a      (w_a_byte),
    .i_b      (w_b_byte),
    .i_cin    (r_carry),
    .o_sum_c  (w_sum),
    .o_cout_c (w_cout)
  );

  // State register; busy/done registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture and per-byte datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= (sub == OP_SUB) ? ~b : b;
            r_carry  <= (sub == OP_SUB);
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
          end
        end
        ST_RUN: begin
          for (int unsigned i = 0; i < NBYTES; i++) begin
            if (r_idx == IDX_W'(i)) r_result[BYTE_W*i +: BYTE_W] <= w_sum;
          end
          r_carry <= w_cout;
          if (w_last) begin
            r_cout <= w_cout;
            // Top byte: operand sign bits are bit 7 of the adder inputs.
            r_ovf  <= (w_a_byte[7] == w_b_byte[7]) && (w_sum[7] != w_a_byte[7]);
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule
